// File: rtl/signexpmd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signexpmd : sign/exponent stage of the FPU multiply/divide unit (1-cycle).
// Rev 1.0
// ---------------------------------------------------------------------------
module signexpmd #(
  parameter int EW   = 11,
  parameter int LZW  = 6,
  parameter int QW   = 13,
  parameter int BIAS = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          sa,
  input  logic [EW-1:0] ea,
  input  logic [LZW-1:0] lza,
  input  logic          sb,
  input  logic [EW-1:0] eb,
  input  logic [LZW-1:0] lzb,
  input  logic          fdiv,
  output logic          out_valid,
  output logic          sq,
  output logic [QW-1:0] eq,
  output logic          eq_ovf,
  output logic          eq_unf
);

  localparam logic signed [QW-1:0] C_EXP_MAX = QW'((2 ** EW) - 1);
  localparam logic signed [QW-1:0] C_BIAS    = QW'(BIAS);
  localparam logic signed [QW-1:0] C_ONE     = QW'(1);

  logic signed [QW-1:0] ua_w, ub_w, eq_d;
  logic                 sq_d, ovf_d, unf_d;

  logic                 valid_q, sq_q, ovf_q, unf_q;
  logic        [QW-1:0] eq_q;

  // A zero exponent field is a denormal whose true exponent is 1.
  always_comb begin
    ua_w  = ((ea == '0) ? C_ONE : QW'(ea)) - QW'(lza);
    ub_w  = ((eb == '0) ? C_ONE : QW'(eb)) - QW'(lzb);
    sq_d  = sa ^ sb;
    if (fdiv) eq_d = ua_w - ub_w + C_BIAS;
    else      eq_d = ua_w + ub_w - C_BIAS;
    ovf_d = (eq_d >= C_EXP_MAX);
    unf_d = eq_d[QW-1] || (eq_d == '0);
  end

  // Flags are registered so they clear on reset alongside eq.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sq_q    <= 1'b0;
      eq_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sq_q  <= sq_d;
        eq_q  <= eq_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign sq        = sq_q;
  assign eq        = eq_q;
  assign eq_ovf    = ovf_q;
  assign eq_unf    = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_signexpmd.sv
`default_nettype none
// tb_signexpmd : table-driven and randomized checks of signexpmd.
module tb_signexpmd;

  typedef struct {
    logic        sa;
    logic [10:0] ea;
    logic [5:0]  lza;
    logic        sb;
    logic [10:0] eb;
    logic [5:0]  lzb;
    logic        fdiv;
    logic        esq;
    int          eeq;
    logic        eovf;
    logic        eunf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, sa, sb, fdiv;
  logic [10:0] ea, eb;
  logic [5:0]  lza, lzb;
  logic        out_valid, sq, eq_ovf, eq_unf;
  logic [12:0] eq;

  int checks = 0;
  int failures = 0;

  signexpmd dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .sa(sa), .ea(ea), .lza(lza), .sb(sb), .eb(eb), .lzb(lzb), .fdiv(fdiv),
    .out_valid(out_valid), .sq(sq), .eq(eq), .eq_ovf(eq_ovf), .eq_unf(eq_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference: exponent arithmetic straight from the rules, using plain integers.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int ua, ub, e;
    ua = ((v.ea == 0) ? 1 : int'(v.ea)) - int'(v.lza);
    ub = ((v.eb == 0) ? 1 : int'(v.eb)) - int'(v.lzb);
    e  = v.fdiv ? (ua - ub + 1023) : (ua + ub - 1023);
    r.esq  = v.sa ^ v.sb;
    r.eeq  = e;
    r.eovf = (e >= 2047);
    r.eunf = (e <= 0);
    return r;
  endfunction

  task automatic drive(input vec_t v, input logic vld);
    in_valid = vld;
    sa = v.sa; ea = v.ea; lza = v.lza;
    sb = v.sb; eb = v.eb; lzb = v.lzb; fdiv = v.fdiv;
  endtask

  task automatic check_out(input string nm, input logic evld, input vec_t e);
    logic [31:0] eb32;
    eb32 = 32'(e.eeq);
    chk({nm, ".valid"}, 32'(out_valid), 32'(evld));
    chk({nm, ".sq"},    32'(sq),        32'(e.esq));
    chk({nm, ".eq"},    32'(eq),        {19'd0, eb32[12:0]});
    chk({nm, ".ovf"},   32'(eq_ovf),    32'(e.eovf));
    chk({nm, ".unf"},   32'(eq_unf),    32'(e.eunf));
  endtask

  function automatic vec_t mk(input logic a, input int ea_, input int la, input logic b,
                              input int eb_, input int lb, input logic fd,
                              input logic s, input int e, input logic o, input logic u);
    vec_t v;
    v.sa = a; v.ea = 11'(ea_); v.lza = 6'(la);
    v.sb = b; v.eb = 11'(eb_); v.lzb = 6'(lb); v.fdiv = fd;
    v.esq = s; v.eeq = e; v.eovf = o; v.eunf = u;
    return v;
  endfunction

  vec_t tbl[7];
  vec_t last, rv, zero_v;

  initial begin
    tbl[0] = mk(0,  682, 42, 0, 1365, 21, 0, 0,   961, 0, 0);
    tbl[1] = mk(1, 1706,  7, 0, 1330, 56, 0, 1,  1950, 0, 0);
    tbl[2] = mk(1, 1023, 63, 1, 2046,  0, 0, 0,  1983, 0, 0);
    tbl[3] = mk(0,    1, 37, 1, 2047, 26, 1, 1, -1034, 0, 1);
    tbl[4] = mk(0,    0,  0, 0,    0,  0, 0, 0, -1021, 0, 1);
    tbl[5] = mk(0, 2046,  0, 0, 2046,  0, 0, 0,  3069, 1, 0);
    tbl[6] = mk(1, 1023,  0, 0, 1023,  0, 1, 1,  1023, 0, 0);
    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with valid operands presented: outputs must stay cleared.
    rst_n = 1'b0;
    drive(tbl[1], 1'b1);
    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, zero_v);

    // Release: first operand set appears one cycle later.
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[0], 1'b1);
    @(negedge clk);
    check_out("rel", 1'b1, tbl[0]);

    // Table vectors applied back-to-back (continuous in_valid).
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i], 1'b1);
      @(negedge clk);
      check_out($sformatf("tbl%0d", i), 1'b1, tbl[i]);
    end
    last = tbl[6];

    // Gap: out_valid drops while results hold, even with new operands present.
    drive(tbl[3], 1'b0);
    @(negedge clk);
    check_out("gap1", 1'b0, last);
    @(negedge clk);
    check_out("gap2", 1'b0, last);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      rv.sa = 1'($urandom); rv.sb = 1'($urandom); rv.fdiv = 1'($urandom);
      rv.ea = 11'($urandom); rv.eb = 11'($urandom);
      if ($urandom_range(0, 7) == 0) rv.ea = 11'd0;
      if ($urandom_range(0, 7) == 0) rv.eb = 11'h7FF;
      rv.lza = 6'($urandom); rv.lzb = 6'($urandom);
      rv = model(rv);
      if ($urandom_range(0, 3) != 0) begin
        drive(rv, 1'b1);
        last = rv;
        @(negedge clk);
        check_out("rnd", 1'b1, last);
      end else begin
        drive(rv, 1'b0);
        @(negedge clk);
        check_out("rndgap", 1'b0, last);
      end
    end

    // Reset mid-stream clears everything again.
    rst_n = 1'b0;
    drive(tbl[5], 1'b1);
    @(negedge clk);
    check_out("reset2", 1'b0, zero_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
